// File: rtl/mux8_1_tree_pkg.sv
// ============================================================================
// Module  : mux8_1_tree_pkg
// Brief   : Shared sizing constants for the 8:1 mux tree.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux8_1_tree_pkg;

    localparam int NLANES = 8;
    localparam int SEL_W  = $clog2(NLANES);

endpackage : mux8_1_tree_pkg

`default_nettype wire

// File: rtl/mux2_1.sv
// ============================================================================
// Module  : mux2_1
// Brief   : 1-bit 2:1 mux cell; leaf of the mux trees, also usable standalone.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_1 (
    output logic out,
    input  logic i0,
    input  logic i1,
    input  logic sel
);

    assign out = sel ? i1 : i0;

endmodule : mux2_1

`default_nettype wire

// File: rtl/mux8_1_tree.sv
// ============================================================================
// Module  : mux8_1_tree
// Brief   : 8:1 mux as a balanced tree of mux2_1 cells, plus registered copy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux8_1_tree
    import mux8_1_tree_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NLANES*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    en,
    output logic [WIDTH-1:0]        out,
    output logic [WIDTH-1:0]        out_q
);

    logic [WIDTH-1:0] out_d;

    genvar b, n;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_bit
            logic [NLANES/2-1:0] w_s0;
            logic [NLANES/4-1:0] w_s1;

            // Stage 0 pairs adjacent lanes on sel[0]
            for (n = 0; n < NLANES/2; n++) begin : g_s0
                mux2_1 u_mux (
                    .out (w_s0[n]),
                    .i0  (in[(2*n)*WIDTH + b]),
                    .i1  (in[(2*n+1)*WIDTH + b]),
                    .sel (sel[0])
                );
            end

            for (n = 0; n < NLANES/4; n++) begin : g_s1
                mux2_1 u_mux (
                    .out (w_s1[n]),
                    .i0  (w_s0[2*n]),
                    .i1  (w_s0[2*n+1]),
                    .sel (sel[1])
                );
            end

            mux2_1 u_s2 (
                .out (out[b]),
                .i0  (w_s1[0]),
                .i1  (w_s1[1]),
                .sel (sel[2])
            );
        end
    endgenerate

    assign out_d = en ? out : out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

endmodule : mux8_1_tree

`default_nettype wire

// File: tb/tb_mux8_1_tree.sv
// ============================================================================
// Module  : tb_mux8_1_tree
// Brief   : Self-checking bench for mux8_1_tree, mux2_1 and a 16:1 composition.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux8_1_tree;

    typedef struct {
        logic [7:0] in;
        logic [2:0] sel;
        logic       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;

    logic [31:0] in4;
    logic [2:0]  sel4;
    logic [3:0]  out4, outq4;

    logic [7:0]  in1;
    logic [2:0]  sel1;
    logic        out1, outq1;

    logic [15:0] in16;
    logic [3:0]  sel16;
    logic        lo_o, hi_o, lo_q, hi_q, out16;

    logic        m_i0, m_i1, m_sel, m_out;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mux8_1_tree #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .in(in4), .sel(sel4), .en(en),
        .out(out4), .out_q(outq4)
    );

    mux8_1_tree #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .in(in1), .sel(sel1), .en(en),
        .out(out1), .out_q(outq1)
    );

    mux8_1_tree #(.WIDTH(1)) u_lo (
        .clk(clk), .reset(reset), .in(in16[7:0]), .sel(sel16[2:0]), .en(en),
        .out(lo_o), .out_q(lo_q)
    );

    mux8_1_tree #(.WIDTH(1)) u_hi (
        .clk(clk), .reset(reset), .in(in16[15:8]), .sel(sel16[2:0]), .en(en),
        .out(hi_o), .out_q(hi_q)
    );

    mux2_1 u_top16 (.out(out16), .i0(lo_o), .i1(hi_o), .sel(sel16[3]));

    mux2_1 u_m2 (.out(m_out), .i0(m_i0), .i1(m_i1), .sel(m_sel));

    // Reference: lane s of a packed 4-bit-lane word
    function automatic logic [3:0] lane4(input logic [31:0] v, input int s);
        return 4'((v >> (s * 4)) & 32'hF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vec_t        tbl[16];
        int          seq_a[8] = '{0, 1, 0, 1, 0, 0, 1, 1};
        int          seq_b[8] = '{1, 0, 1, 0, 1, 1, 0, 0};
        logic [3:0]  exp_q;
        logic [15:0] pat;
        logic [2:0]  c;

        for (int i = 0; i < 8; i++) begin
            tbl[i]     = '{8'hCA, 3'(i), 1'(seq_a[i])};
            tbl[i + 8] = '{8'h35, 3'(i), 1'(seq_b[i])};
        end

        reset = 1'b1; en = 1'b0;
        in4 = '0; sel4 = '0; in1 = '0; sel1 = '0;
        in16 = '0; sel16 = '0; m_i0 = 0; m_i1 = 0; m_sel = 0;
        #2;
        chk("reset_outq4", 32'(outq4), 32'h0);
        chk("reset_outq1", 32'(outq1), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // WIDTH=1 sel sweeps from table
        for (int i = 0; i < 16; i++) begin
            in1 = tbl[i].in; sel1 = tbl[i].sel;
            #10;
            chk($sformatf("w1_sweep_%0d", i), 32'(out1), 32'(tbl[i].exp));
        end

        // WIDTH=4 load then hold
        @(negedge clk);
        in4 = 32'h76543210; sel4 = 3'd5; en = 1'b1;
        #1 chk("w4_out_sel5", 32'(out4), 32'h5);
        @(posedge clk); #1 chk("w4_load", 32'(outq4), 32'h5);
        @(negedge clk);
        en = 1'b0; sel4 = 3'd2;
        #1 chk("w4_out_sel2", 32'(out4), 32'h2);
        @(posedge clk); #1 chk("w4_hold", 32'(outq4), 32'h5);

        // Async reset between edges, held across an enabled edge
        @(negedge clk);
        reset = 1'b1;
        #1 chk("async_clear", 32'(outq4), 32'h0);
        chk("out_ignores_reset", 32'(out4), 32'h2);
        en = 1'b1; sel4 = 3'd7;
        @(posedge clk); #1 chk("held_in_reset", 32'(outq4), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1 chk("reload_after_reset", 32'(outq4), 32'h7);

        // mux2_1 standalone
        for (int i = 0; i < 8; i++) begin
            c = 3'(i);
            m_i0 = c[0]; m_i1 = c[1]; m_sel = c[2];
            #1 chk($sformatf("mux2_%0d", i), 32'(m_out), 32'(c[2] ? c[1] : c[0]));
        end

        // 16:1 composition
        for (int p = 0; p < 2; p++) begin
            pat = (p == 0) ? 16'h39CA : ~16'h39CA;
            for (int s = 0; s < 16; s++) begin
                in16 = pat; sel16 = 4'(s);
                #1 chk($sformatf("mux16_p%0d_s%0d", p, s), 32'(out16), 32'(pat[s]));
            end
        end

        // Randomized against the lane model
        exp_q = outq4;
        exp_q = 4'h7;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in4  = $urandom;
            sel4 = 3'($urandom_range(0, 7));
            en   = 1'($urandom_range(0, 1));
            #1 chk("rand_out", 32'(out4), 32'(lane4(in4, int'(sel4))));
            @(posedge clk);
            if (en) exp_q = lane4(in4, int'(sel4));
            #1 chk("rand_outq", 32'(outq4), 32'(exp_q));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mux8_1_tree

`default_nettype wire

// File: doc/mux8_1_tree.md
Name: mux8_1_tree

Overview:
- 8:1 multiplexer built as a balanced tree of 2:1 mux cells.
- Selects one of eight data lanes with a 3-bit select.
- Provides a combinational output and a registered copy.
- Used as the building block for wider selectors, e.g. 16:1 = two 8:1 trees plus one 2:1 stage on sel[3], and for register-file read ports.

Parameters:
- WIDTH, 1, bits per data lane; all eight lanes and both outputs are WIDTH bits.

Ports:
- clk     input   1        rising-edge clock for the registered output
- reset   input   1        asynchronous, active-high; clears out_q
- in      input   8*WIDTH  packed lanes; lane k = in[k*WIDTH +: WIDTH], k=0..7
- sel     input   3        lane select, unsigned, 0..7
- en      input   1        load enable for out_q
- out     output  WIDTH    combinational selected lane
- out_q   output  WIDTH    registered selected lane

Behaviour:
- out = lane[sel], purely combinational, with no clock dependence.
- out settles within 10 ns of any change on in or sel.
- out is unaffected by reset.
- Tree structure (bitwise across WIDTH):
  - Stage 0: four mux2_1 cells on sel[0], pairing lanes (0,1) (2,3) (4,5) (6,7).
  - Stage 1: two mux2_1 cells on sel[1].
  - Stage 2: one mux2_1 cell on sel[2].
- mux2_1 cell: out = sel ? i1 : i0.
- All sel values 0..7 are legal; there is no out-of-range case.
- X/Z on sel: output is don't-care.
- out_q:
  - On reset asserted, out_q = 0 immediately (asynchronous), regardless of clk.
  - Held at 0 while reset is high.
  - On rising clk with reset low and en=1: out_q <= out, i.e. lane[sel] sampled at the edge.
  - On rising clk with en=0: out_q holds its value.
- Latency: out has 0 cycles; out_q has 1 cycle.
- Reset deassertion takes effect for the next rising edge; the edge coincident with deassertion is not required to load.
- Simultaneous change of sel and in: out reflects the final values after settling; no glitch-freedom is required.

Decomposition:
- Shared package: none required. Lane-index helper constant NLANES = 8 may live locally.
- Sub-module mux2_1 (1-bit): ports out, i0, i1, sel.
  - Instantiated per bit per tree node, via a generate loop over WIDTH.
- mux2_1 is also exported standalone for use by higher-level muxes (mux16_1 composition).

Test Plan:
- WIDTH=1, in=8'hCA, sel swept 0..7 with a 10 ns step -> out = in[sel], i.e. 0,1,0,1,0,0,1,1 for sel=0..7.
- WIDTH=1, in=~8'hCA=8'h35, sel swept 0..7 -> out = 1,0,1,0,1,1,0,0; every lane is shown to pass both 0 and 1.
- WIDTH=4, in=32'h76543210, sel=5 -> out=4'h5; en=1, one clk edge -> out_q=4'h5; then en=0, sel=2, edge -> out_q stays 4'h5 while out=4'h2.
- Reset mid-operation: out_q=4'h5, reset pulsed high between clk edges -> out_q=0 immediately while out still equals the selected lane; after release, en=1 with the next edge -> out_q reloads.
- mux2_1 standalone, all 8 combinations of (i0,i1,sel) -> out = sel ? i1 : i0.
- Composition check: two instances plus a mux2_1 on sel[3] as a 16:1, in=16'h39CA and then ~16'h39CA, sel 0..15 -> out = in[sel].
